// File: rtl/spi_target_regs.sv
// SPI mode-0 target with a small byte-addressed register bank.
// The SPI pins are oversampled by clk; commands WRITE (02), READ (03) and
// ID (9F) are decoded, and MISO is driven from a registered shift path.
module spi_target_regs #(
   parameter int          ADDR_W  = 4,
   parameter logic [7:0]  ID_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_cs_n,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   input  logic [ADDR_W-1:0] loc_addr,
   output logic [7:0]        loc_rdata,
   output logic              wr_stb,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CMD    = 3'd1;
   localparam logic [2:0] S_ADDR   = 3'd2;
   localparam logic [2:0] S_WDATA  = 3'd3;
   localparam logic [2:0] S_RDATA  = 3'd4;
   localparam logic [2:0] S_IGNORE = 3'd5;

   // Synchronizer chains; index 1 is the synchronized level, index 2 the
   // previous level used for edge detection. CS/SCLK chains reset to 0 so
   // that a CS held low through reset never produces a falling edge: the
   // pin has to be seen high first.
   logic [2:0] cs_q;
   logic [2:0] sclk_q;
   logic [1:0] mosi_q;

   logic       sclk_rise;
   logic       sclk_fall;
   logic       cs_fall;
   logic       cs_rise;
   logic       mosi_bit;

   logic [2:0]        state_q,     state_d;
   logic [2:0]        bit_cnt_q,   bit_cnt_d;
   logic [ADDR_W-1:0] ptr_q,       ptr_d;
   logic              is_rd_q,     is_rd_d;
   logic              id_q,        id_d;
   logic              load_pend_q, load_pend_d;
   logic              miso_q,      miso_d;
   logic              busy_q,      busy_d;
   logic              wr_stb_q,    wr_stb_d;
   logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
   logic [7:0]        wr_data_q,   wr_data_d;
   logic [7:0]        rx_sh_q,     rx_sh_d;
   logic [7:0]        tx_sh_q,     tx_sh_d;

   logic [7:0]        bank_q [DEPTH];
   logic              bank_we;
   logic              byte_done;
   logic [7:0]        rx_byte;
   logic [7:0]        tx_word;

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign cs_fall   = ~cs_q[1] & cs_q[2];
   assign cs_rise   = cs_q[1] & ~cs_q[2];
   assign mosi_bit  = mosi_q[1];

   assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
   assign rx_byte   = {rx_sh_q[6:0], mosi_bit};
   assign tx_word   = id_q ? ID_BYTE : bank_q[ptr_q];

   assign spi_miso  = miso_q;
   assign busy      = busy_q;
   assign wr_stb    = wr_stb_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign loc_rdata = bank_q[loc_addr];

   // Pin synchronizers plus one extra stage for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_q   <= 3'b000;
         sclk_q <= 3'b000;
         mosi_q <= 2'b00;
      end else begin
         cs_q   <= {cs_q[1:0], spi_cs_n};
         sclk_q <= {sclk_q[1:0], spi_sclk};
         mosi_q <= {mosi_q[0], spi_mosi};
      end
   end

   // Protocol state machine and output next-state logic
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      ptr_d       = ptr_q;
      is_rd_d     = is_rd_q;
      id_d        = id_q;
      load_pend_d = load_pend_q;
      miso_d      = miso_q;
      busy_d      = busy_q;
      wr_stb_d    = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      rx_sh_d     = rx_sh_q;
      tx_sh_d     = tx_sh_q;
      bank_we     = 1'b0;

      if (state_q == S_IDLE) begin
         miso_d = 1'b0;
         if (cs_fall) begin
            state_d     = S_CMD;
            bit_cnt_d   = 3'd0;
            busy_d      = 1'b1;
            id_d        = 1'b0;
            is_rd_d     = 1'b0;
            load_pend_d = 1'b0;
         end
      end else begin
         if (sclk_rise) begin
            rx_sh_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
         end

         case (state_q)
            S_CMD: begin
               if (byte_done) begin
                  case (rx_byte)
                     8'h02: begin
                        is_rd_d = 1'b0;
                        state_d = S_ADDR;
                     end
                     8'h03: begin
                        is_rd_d = 1'b1;
                        state_d = S_ADDR;
                     end
                     8'h9F: begin
                        id_d        = 1'b1;
                        load_pend_d = 1'b1;
                        state_d     = S_RDATA;
                     end
                     default: state_d = S_IGNORE;
                  endcase
               end
            end
            S_ADDR: begin
               if (byte_done) begin
                  ptr_d = rx_byte[ADDR_W-1:0];
                  if (is_rd_q) begin
                     load_pend_d = 1'b1;
                     state_d     = S_RDATA;
                  end else begin
                     state_d = S_WDATA;
                  end
               end
            end
            S_WDATA: begin
               if (byte_done) begin
                  bank_we   = 1'b1;
                  wr_stb_d  = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = rx_byte;
                  ptr_d     = ptr_q + ADDR_W'(1);
               end
            end
            S_RDATA: begin
               // The first falling edge after a completed byte loads the
               // next outgoing byte; every other falling edge shifts.
               if (byte_done) begin
                  load_pend_d = 1'b1;
               end
               if (sclk_fall) begin
                  if (load_pend_q) begin
                     tx_sh_d     = tx_word;
                     miso_d      = tx_word[7];
                     ptr_d       = ptr_q + ADDR_W'(1);
                     load_pend_d = 1'b0;
                  end else begin
                     miso_d  = tx_sh_q[6];
                     tx_sh_d = {tx_sh_q[6:0], 1'b0};
                  end
               end
            end
            default: miso_d = 1'b0;
         endcase

         // CS release ends any transaction; a partial byte is dropped
         if (cs_rise) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            bit_cnt_d   = 3'd0;
            miso_d      = 1'b0;
            load_pend_d = 1'b0;
         end
      end
   end

   // Control and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= 3'd0;
         ptr_q       <= '0;
         is_rd_q     <= 1'b0;
         id_q        <= 1'b0;
         load_pend_q <= 1'b0;
         miso_q      <= 1'b0;
         busy_q      <= 1'b0;
         wr_stb_q    <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         ptr_q       <= ptr_d;
         is_rd_q     <= is_rd_d;
         id_q        <= id_d;
         load_pend_q <= load_pend_d;
         miso_q      <= miso_d;
         busy_q      <= busy_d;
         wr_stb_q    <= wr_stb_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   // Shift registers carry only data and need no reset
   always_ff @(posedge clk) begin
      rx_sh_q <= rx_sh_d;
      tx_sh_q <= tx_sh_d;
   end

   // Register bank, cleared by reset, written one byte per SPI data byte
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            bank_q[i] <= 8'h00;
         end
      end else if (bank_we) begin
         bank_q[ptr_q] <= rx_byte;
      end
   end

endmodule

// File: tb/tb_spi_target_regs.sv
// Directed bench for spi_target_regs: SPI master model at SCLK = clk/8,
// write-strobe logger, and hand-computed expected bytes.
module tb_spi_target_regs;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       spi_cs_n = 1'b1;
   logic       spi_sclk = 1'b0;
   logic       spi_mosi = 1'b0;
   logic       spi_miso;
   logic [3:0] loc_addr = 4'd0;
   logic [7:0] loc_rdata;
   logic       wr_stb;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;

   int ncmp = 0;
   int nerr = 0;

   int         wcnt = 0;
   logic [3:0] wa_log [16];
   logic [7:0] wd_log [16];

   spi_target_regs #(.ADDR_W(4), .ID_BYTE(8'hA5)) dut (
      .clk       (clk),
      .rst       (rst),
      .spi_cs_n  (spi_cs_n),
      .spi_sclk  (spi_sclk),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .loc_addr  (loc_addr),
      .loc_rdata (loc_rdata),
      .wr_stb    (wr_stb),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Log every write strobe, sampled away from the active edge
   always @(negedge clk) begin
      if (wr_stb) begin
         if (wcnt < 16) begin
            wa_log[wcnt] = wr_addr;
            wd_log[wcnt] = wr_data;
         end
         wcnt = wcnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Send n bits of tx MSB first; MISO is captured just before each rise
   task automatic xfer(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < n; i++) begin
         spi_mosi = tx[7-i];
         clks(4);
         rx[7-i] = spi_miso;
         spi_sclk = 1'b1;
         clks(4);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic cs_start();
      @(negedge clk);
      spi_cs_n = 1'b0;
      clks(4);
   endtask

   task automatic cs_end();
      clks(4);
      spi_cs_n = 1'b1;
      clks(8);
   endtask

   logic [7:0] rx;
   int         w0;

   initial begin
      clks(4);
      rst = 1'b0;
      clks(2);

      // Reset state
      chk("rst_miso", 32'(spi_miso), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_wr_stb", 32'(wr_stb), 32'h0);
      chk("rst_wr_addr", 32'(wr_addr), 32'h0);
      chk("rst_wr_data", 32'(wr_data), 32'h0);
      chk("rst_bank", 32'(loc_rdata), 32'h0);

      // WRITE 02,03,11,22,33
      cs_start();
      chk("busy_rise", 32'(busy), 32'h1);
      xfer(8'h02, 8, rx);
      xfer(8'h03, 8, rx);
      xfer(8'h11, 8, rx);
      xfer(8'h22, 8, rx);
      xfer(8'h33, 8, rx);
      cs_end();
      chk("wr_count", 32'(wcnt), 32'd3);
      chk("wr0_addr", 32'(wa_log[0]), 32'h3);
      chk("wr0_data", 32'(wd_log[0]), 32'h11);
      chk("wr1_addr", 32'(wa_log[1]), 32'h4);
      chk("wr1_data", 32'(wd_log[1]), 32'h22);
      chk("wr2_addr", 32'(wa_log[2]), 32'h5);
      chk("wr2_data", 32'(wd_log[2]), 32'h33);
      chk("wr_addr_hold", 32'(wr_addr), 32'h5);
      loc_addr = 4'd4;
      #1;
      chk("loc_rdata4", 32'(loc_rdata), 32'h22);

      // READ 03,03 + 3 dummy bytes
      w0 = wcnt;
      cs_start();
      xfer(8'h03, 8, rx);
      xfer(8'h03, 8, rx);
      chk("rd_busy_mid", 32'(busy), 32'h1);
      xfer(8'h00, 8, rx);
      chk("rd_byte0", 32'(rx), 32'h11);
      xfer(8'hFF, 8, rx);
      chk("rd_byte1", 32'(rx), 32'h22);
      xfer(8'h00, 8, rx);
      chk("rd_byte2", 32'(rx), 32'h33);
      chk("rd_busy_end", 32'(busy), 32'h1);
      cs_end();
      chk("rd_busy_after", 32'(busy), 32'h0);
      chk("rd_no_write", 32'(wcnt), 32'(w0));

      // Address wrap: WRITE 02,0F,AA,BB then READ it back
      cs_start();
      xfer(8'h02, 8, rx);
      xfer(8'h0F, 8, rx);
      xfer(8'hAA, 8, rx);
      xfer(8'hBB, 8, rx);
      cs_end();
      loc_addr = 4'd15;
      #1;
      chk("wrap_bank15", 32'(loc_rdata), 32'hAA);
      loc_addr = 4'd0;
      #1;
      chk("wrap_bank0", 32'(loc_rdata), 32'hBB);
      cs_start();
      xfer(8'h03, 8, rx);
      xfer(8'h0F, 8, rx);
      xfer(8'h00, 8, rx);
      chk("wrap_rd0", 32'(rx), 32'hAA);
      xfer(8'h00, 8, rx);
      chk("wrap_rd1", 32'(rx), 32'hBB);
      cs_end();

      // ID command
      cs_start();
      xfer(8'h9F, 8, rx);
      xfer(8'h00, 8, rx);
      chk("id_byte0", 32'(rx), 32'hA5);
      xfer(8'h00, 8, rx);
      chk("id_byte1", 32'(rx), 32'hA5);
      cs_end();

      // Unknown command is ignored
      w0 = wcnt;
      cs_start();
      xfer(8'h5A, 8, rx);
      chk("unk_cmd_miso", 32'(rx), 32'h0);
      xfer(8'h00, 8, rx);
      chk("unk_b1_miso", 32'(rx), 32'h0);
      xfer(8'hFF, 8, rx);
      chk("unk_b2_miso", 32'(rx), 32'h0);
      cs_end();
      chk("unk_no_write", 32'(wcnt), 32'(w0));

      // Abort mid-byte: WRITE 02,07 then 5 bits only
      w0 = wcnt;
      cs_start();
      xfer(8'h02, 8, rx);
      xfer(8'h07, 8, rx);
      xfer(8'hFF, 5, rx);
      cs_end();
      chk("abort_no_write", 32'(wcnt), 32'(w0));
      loc_addr = 4'd7;
      #1;
      chk("abort_bank7", 32'(loc_rdata), 32'h00);
      cs_start();
      xfer(8'h02, 8, rx);
      xfer(8'h07, 8, rx);
      xfer(8'h77, 8, rx);
      cs_end();
      chk("post_abort_cnt", 32'(wcnt), 32'(w0 + 1));
      chk("post_abort_bank7", 32'(loc_rdata), 32'h77);

      // Reset during READ with CS held low
      cs_start();
      xfer(8'h03, 8, rx);
      xfer(8'h03, 8, rx);
      xfer(8'h00, 4, rx);
      rst = 1'b1;
      clks(2);
      rst = 1'b0;
      chk("midrst_miso", 32'(spi_miso), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      loc_addr = 4'd3;
      #1;
      chk("midrst_bank3", 32'(loc_rdata), 32'h00);
      w0 = wcnt;
      xfer(8'h02, 8, rx);
      xfer(8'h01, 8, rx);
      xfer(8'h5C, 8, rx);
      chk("midrst_ignored_miso", 32'(rx), 32'h0);
      chk("midrst_ignored_busy", 32'(busy), 32'h0);
      chk("midrst_ignored_wr", 32'(wcnt), 32'(w0));
      cs_end();
      cs_start();
      chk("midrst_rearm_busy", 32'(busy), 32'h1);
      xfer(8'h02, 8, rx);
      xfer(8'h01, 8, rx);
      xfer(8'h5C, 8, rx);
      cs_end();
      loc_addr = 4'd1;
      #1;
      chk("midrst_rearm_bank1", 32'(loc_rdata), 32'h5C);
      chk("midrst_rearm_addr", 32'(wr_addr), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
